// File: rtl/prog_ram_pkg.sv
// prog_ram_pkg: shared types and constants for the program/data RAM.
// Holds the FSM state enum, default widths, the HALT fill word and the
// default boot image, which is exposed through image_word().
package prog_ram_pkg;

    localparam int unsigned DEF_ADDR_W   = 4;
    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_BOOT_LEN = 10;
    localparam int unsigned IMAGE_LEN    = 10;

    // HALT opcode with a zero operand.
    localparam logic [7:0] DEF_FILL_WORD = 8'hB0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default program image; indices outside the image return the fill word.
    function automatic logic [7:0] image_word(input int unsigned idx);
        logic [7:0] w_word;
        case (idx)
            0:       w_word = 8'h08;
            1:       w_word = 8'h08;
            2:       w_word = 8'h19;
            3:       w_word = 8'h20;
            4:       w_word = 8'h10;
            5:       w_word = 8'h70;
            6:       w_word = 8'h00;
            7:       w_word = 8'h14;
            8:       w_word = 8'h04;
            9:       w_word = 8'hB3;
            default: w_word = DEF_FILL_WORD;
        endcase
        return w_word;
    endfunction

endpackage

// File: rtl/prog_ram_if.sv
// prog_ram_if: CPU-side access bus for prog_ram.
// master (CPU/bench) drives addr, rd_en, wr_en, wdata, reload;
// slave (prog_ram) drives rdata, rvalid, busy, err.
interface prog_ram_if
    import prog_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic [ADDR_W-1:0] addr;
    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] wdata;
    logic              reload;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              busy;
    logic              err;

    modport master (
        output addr, rd_en, wr_en, wdata, reload,
        input  rdata, rvalid, busy, err
    );

    modport slave (
        input  addr, rd_en, wr_en, wdata, reload,
        output rdata, rvalid, busy, err
    );

endinterface

// File: rtl/prog_ram_boot_rom.sv
// prog_ram_boot_rom: combinational boot-copy pointer -> image word lookup.
// Ports:
//   i_ptr    in  ADDR_W  copy pointer
//   o_word_c out DATA_W  image word for i_ptr, or FILL_WORD past BOOT_LEN
module prog_ram_boot_rom
    import prog_ram_pkg::*;
#(
    parameter int unsigned        ADDR_W    = DEF_ADDR_W,
    parameter int unsigned        DATA_W    = DEF_DATA_W,
    parameter int unsigned        BOOT_LEN  = DEF_BOOT_LEN,
    parameter logic [DATA_W-1:0]  FILL_WORD = DATA_W'(DEF_FILL_WORD)
) (
    input  logic [ADDR_W-1:0] i_ptr,
    output logic [DATA_W-1:0] o_word_c
);

    logic [31:0] w_idx;

    assign w_idx = 32'(i_ptr);

    // Image words beyond the table length are treated as fill as well.
    always_comb begin
        o_word_c = FILL_WORD;
        if ((w_idx < BOOT_LEN) && (w_idx < IMAGE_LEN)) begin
            o_word_c = DATA_W'(image_word(w_idx));
        end
    end

endmodule

// File: rtl/prog_ram.sv
// prog_ram: synchronous program/data RAM with a boot-copy FSM.
// After reset (or a reload pulse in RUN) the FSM copies the boot image into
// all DEPTH words, one per clock, holding busy high. CPU accesses are only
// honoured in RUN; accesses while copying are dropped and flag err.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave prog_ram_if: addr/rd_en/wr_en/wdata/reload in,
//               rdata/rvalid/busy/err out (all registered)
// Build option: PROG_RAM_WRITE_THROUGH_EN selects write-first read data for
// simultaneous rd_en+wr_en; default is read-first (old contents).
module prog_ram
    import prog_ram_pkg::*;
#(
    parameter int unsigned        ADDR_W    = DEF_ADDR_W,
    parameter int unsigned        DATA_W    = DEF_DATA_W,
    parameter int unsigned        BOOT_LEN  = DEF_BOOT_LEN,
    parameter logic [DATA_W-1:0]  FILL_WORD = DATA_W'(DEF_FILL_WORD)
) (
    input  logic       clk,
    input  logic       rst_n,
    prog_ram_if.slave  bus
);

    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              r_rvalid;
    logic              w_rvalid_nxt;
    logic              r_err;
    logic              w_err_nxt;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    logic [DATA_W-1:0] w_boot_word;
    logic              w_access;

    prog_ram_boot_rom #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BOOT_LEN  (BOOT_LEN),
        .FILL_WORD (FILL_WORD)
    ) u_boot_rom (
        .i_ptr    (r_ptr),
        .o_word_c (w_boot_word)
    );

    assign w_access = bus.rd_en | bus.wr_en;

    // Next-state, memory port steering and registered output values.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_busy_nxt   = r_busy;
        w_rdata_nxt  = r_rdata;
        w_rvalid_nxt = 1'b0;
        w_err_nxt    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = bus.addr;
        w_mem_wdata  = bus.wdata;

        case (r_state)
            INIT: begin
                // Copy one image word per clock; CPU access and reload ignored.
                w_mem_we    = 1'b1;
                w_mem_addr  = r_ptr;
                w_mem_wdata = w_boot_word;
                w_ptr_nxt   = r_ptr + 1'b1;
                w_err_nxt   = w_access;
                if (r_ptr == LAST_PTR) begin
                    w_state_nxt = RUN;
                    w_busy_nxt  = 1'b0;
                end
            end
            RUN: begin
                if (bus.reload) begin
                    // Reload wins over any access issued in the same cycle.
                    w_state_nxt = INIT;
                    w_ptr_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_err_nxt   = w_access;
                end else begin
                    w_mem_we = bus.wr_en;
                    if (bus.rd_en) begin
                        w_rvalid_nxt = 1'b1;
`ifdef PROG_RAM_WRITE_THROUGH_EN
                        w_rdata_nxt  = bus.wr_en ? bus.wdata : r_mem[bus.addr];
`else
                        w_rdata_nxt  = r_mem[bus.addr];
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = INIT;
                w_ptr_nxt   = '0;
                w_busy_nxt  = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= INIT;
            r_ptr    <= '0;
            r_busy   <= 1'b1;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_busy   <= w_busy_nxt;
            r_rdata  <= w_rdata_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
    assign bus.busy   = r_busy;
    assign bus.err    = r_err;

endmodule

// File: tb/tb_prog_ram.sv
// tb_prog_ram: self-checking bench for prog_ram (default 16x8 configuration).
// Read expectations go into a scoreboard queue when a read is issued and are
// popped when rvalid is seen. Honours PROG_RAM_WRITE_THROUGH_EN.
module tb_prog_ram;

    typedef struct {
        logic [3:0] addr;
        logic       rd;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

`ifdef PROG_RAM_WRITE_THROUGH_EN
    localparam logic [7:0] EXP_RW = 8'hC3;
`else
    localparam logic [7:0] EXP_RW = 8'h70;
`endif

    logic clk;
    logic rst_n;

    prog_ram_if bus ();

    prog_ram dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp;
    int         n_bad;
    logic [7:0] exp_q [$];
    logic [7:0] ref_img [16];
    bit         m_init;
    int         m_cnt;
    vec_t       vecs [14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, update busy model, sample #1 after the edge.
    task automatic step(input logic [3:0] a, input logic rd, input logic wr,
                        input logic [7:0] wd, input logic rl, input logic [7:0] exp);
        logic exp_err;
        logic exp_rv;
        logic [7:0] got;
        bus.addr   = a;
        bus.rd_en  = rd;
        bus.wr_en  = wr;
        bus.wdata  = wd;
        bus.reload = rl;
        exp_err = 1'b0;
        exp_rv  = 1'b0;
        if (m_init) begin
            exp_err = rd | wr;
            m_cnt++;
            if (m_cnt == 16) m_init = 1'b0;
        end else if (rl) begin
            exp_err = rd | wr;
            m_init  = 1'b1;
            m_cnt   = 0;
        end else if (rd) begin
            exp_rv = 1'b1;
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        check("busy", 32'(bus.busy), 32'(m_init));
        check("err", 32'(bus.err), 32'(exp_err));
        check("rvalid", 32'(bus.rvalid), 32'(exp_rv));
        if (bus.rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", 32'(1), 32'(0));
            end else begin
                got = bus.rdata;
                check($sformatf("rdata@%0d", a), 32'(got), 32'(exp_q.pop_front()));
            end
        end else if (exp_rv && exp_q.size() != 0) begin
            void'(exp_q.pop_back());
        end
    endtask

    task automatic idle();
        step(4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    // Run idle clocks until busy drops; the copy must take 16 edges.
    task automatic wait_boot(input string nm, input int already);
        int n;
        n = already;
        while (n < 64) begin
            idle();
            n++;
            if (bus.busy !== 1'b1) break;
        end
        check(nm, 32'(n), 32'(16));
    endtask

    task automatic check_reset_state(input string nm);
        check({nm, "_busy"}, 32'(bus.busy), 32'(1));
        check({nm, "_rvalid"}, 32'(bus.rvalid), 32'(0));
        check({nm, "_rdata"}, 32'(bus.rdata), 32'(0));
        check({nm, "_err"}, 32'(bus.err), 32'(0));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        ref_img = '{8'h08, 8'h08, 8'h19, 8'h20, 8'h10, 8'h70, 8'h00, 8'h14,
                    8'h04, 8'hB3, 8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0};

        vecs[0]  = '{4'd2,  1'b1, 1'b0, 8'h00, 8'h19};
        vecs[1]  = '{4'd9,  1'b1, 1'b0, 8'h00, 8'hB3};
        vecs[2]  = '{4'd12, 1'b1, 1'b0, 8'h00, 8'hB0};
        vecs[3]  = '{4'd3,  1'b0, 1'b1, 8'h5A, 8'h00};
        vecs[4]  = '{4'd3,  1'b1, 1'b0, 8'h00, 8'h5A};
        vecs[5]  = '{4'd4,  1'b1, 1'b0, 8'h00, 8'h10};
        vecs[6]  = '{4'd0,  1'b0, 1'b0, 8'h00, 8'h00};
        vecs[7]  = '{4'd5,  1'b1, 1'b1, 8'hC3, EXP_RW};
        vecs[8]  = '{4'd5,  1'b1, 1'b0, 8'h00, 8'hC3};
        vecs[9]  = '{4'd0,  1'b1, 1'b0, 8'h00, 8'h08};
        vecs[10] = '{4'd15, 1'b0, 1'b1, 8'h33, 8'h00};
        vecs[11] = '{4'd15, 1'b1, 1'b0, 8'h00, 8'h33};
        vecs[12] = '{4'd15, 1'b1, 1'b0, 8'h00, 8'h33};
        vecs[13] = '{4'd6,  1'b1, 1'b0, 8'h00, 8'h00};

        bus.addr   = '0;
        bus.rd_en  = 1'b0;
        bus.wr_en  = 1'b0;
        bus.wdata  = '0;
        bus.reload = 1'b0;
        m_init = 1'b1;
        m_cnt  = 0;

        // Power-on reset.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        rst_n = 1'b1;
        wait_boot("boot_len_por", 0);

        // Table-driven RUN accesses.
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, 1'b0, vecs[i].exp);
        end

        // rdata holds after rvalid drops.
        idle();
        check("rdata_hold", 32'(bus.rdata), 32'(8'h00));
        step(4'd2, 1'b1, 1'b0, 8'h00, 1'b0, 8'h19);
        idle();
        idle();
        check("rdata_hold2", 32'(bus.rdata), 32'(8'h19));

        // Overwrite addr 7, reload with a colliding write, access during copy.
        step(4'd7, 1'b0, 1'b1, 8'hEE, 1'b0, 8'h00);
        step(4'd7, 1'b1, 1'b0, 8'h00, 1'b0, 8'hEE);
        step(4'd7, 1'b0, 1'b1, 8'h99, 1'b1, 8'h00);
        step(4'd0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00);
        step(4'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        wait_boot("boot_len_reload", 2);
        step(4'd7, 1'b1, 1'b0, 8'h00, 1'b0, 8'h14);
        step(4'd0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h08);
        step(4'd3, 1'b1, 1'b0, 8'h00, 1'b0, 8'h20);
        step(4'd5, 1'b1, 1'b0, 8'h00, 1'b0, 8'h70);
        step(4'd15, 1'b1, 1'b0, 8'h00, 1'b0, 8'hB0);

        // Reset in the middle of a copy restarts it from pointer 0.
        step(4'd0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++) idle();
        rst_n = 1'b0;
        m_init = 1'b1;
        m_cnt  = 0;
        exp_q.delete();
        #2;
        check_reset_state("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_boot("boot_len_midrst", 0);
        for (int i = 0; i < 16; i++) begin
            step(4'(i), 1'b1, 1'b0, 8'h00, 1'b0, ref_img[i]);
        end
        idle();
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_ram.md
Name: prog_ram

Overview:
Parametrised synchronous program/data memory for the 4-bit microprocessor, succeeding the fixed combinational program decoder. It holds DEPTH words of DATA_W bits and has one shared address with a read port and a write port. A boot FSM copies the default program image into the array after reset or on request. The CPU fetch/execute unit accesses it only while busy is low.

Parameters:
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, word width (opcode[7:4], operand[3:0] at default).
- BOOT_LEN, 10, number of image words taken from the boot table; must be <= DEPTH.
- FILL_WORD, 8'hB0, value written to addresses BOOT_LEN..DEPTH-1 (HALT opcode).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  ADDR_W  shared read/write address
- rd_en  in  1  read request
- wr_en  in  1  write request
- wdata  in  DATA_W  write data
- reload  in  1  single-cycle pulse that re-runs boot copy
- rdata  out  DATA_W  registered read data
- rvalid  out  1  rdata updated this cycle
- busy  out  1  boot copy in progress
- err  out  1  access attempted while busy

Behaviour:
- Reset (async, rst_n=0): state=INIT, copy pointer=0, busy=1, rdata=0, rvalid=0, err=0. Array contents are not reset.
- FSM states: INIT, RUN.
- INIT: each edge writes image[ptr] to mem[ptr], then ptr++. The edge that writes ptr=DEPTH-1 moves the FSM to RUN.
  - busy=1 for exactly DEPTH edges after rst_n release; busy=0 is registered on that last edge.
- Boot image word: for ptr < BOOT_LEN, it comes from the boot table sub-module; otherwise it is FILL_WORD.
- In INIT, rd_en and wr_en are ignored (no write, rvalid=0). Any rd_en|wr_en raises err=1 on the next cycle for one cycle per offending cycle.
- In INIT, reload is ignored.
- RUN, read:
  - rd_en at edge t gives rdata=mem[addr] and rvalid=1 after edge t (latency 1).
  - rvalid drops to 0 the next cycle if there is no rd_en.
  - rdata holds its last value until the next read.
- RUN, write: wr_en at edge t stores wdata into mem[addr] at edge t.
- RUN, rd_en and wr_en together (same addr by construction): the write always happens. rdata follows the Optional Feature rule.
- RUN, reload=1: ptr=0, busy=1, state=INIT on that edge. Any rd_en/wr_en in the same cycle is dropped and flags err.
- rst_n asserted mid-INIT: the copy restarts from ptr=0 after release.
- Address is used modulo DEPTH (no out-of-range case exists).
- err is 0 in RUN except in the reload cycle described above.

Optional Feature:
- Macro PROG_RAM_WRITE_THROUGH_EN.
- Defined: simultaneous rd_en+wr_en returns wdata on rdata (write-first).
- Undefined: simultaneous rd_en+wr_en returns the pre-write mem[addr] (read-first).
- Both modes keep rvalid=1 and latency 1.

Decomposition:
- Package prog_ram_pkg holds:
  - state enum {INIT, RUN};
  - default DATA_W/ADDR_W constants;
  - FILL_WORD default;
  - boot image constants, in order from index 0 through 9: 08, 08, 19, 20, 10, 70, 00, 14, 04, B3 (hex).
- Sub-module boot_rom: combinational ptr -> word lookup returning the image word or FILL_WORD. It is instantiated once, indexed by the copy pointer.

Test Plan:
- Release reset → busy=1 for exactly 16 edges, then 0. Read addr 2 → rdata=0x19, rvalid=1 one cycle later. Read addr 9 → 0xB3. Read addr 12 → 0xB0.
- RUN: write 0x5A to addr 3, read addr 3 next cycle → 0x5A. Addr 4 still reads 0x10.
- RUN: rd_en+wr_en addr 5, wdata 0xC3 → rdata=0x70 (macro undefined) or 0xC3 (macro defined). A later read of addr 5 → 0xC3 in both modes.
- During INIT: wr_en addr 0 wdata 0xFF → err=1 next cycle. After busy drops, addr 0 reads 0x08.
- Write 0xEE to addr 7, then pulse reload → busy=1 for 16 edges. Addr 7 then reads 0x14 again.
- Assert rst_n=0 at INIT edge 8, release → busy lasts a full 16 edges from release, and all image words read back correct.
